// File: rtl/ffe_sample_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ffe_sample_sequencer_if
//  Description : Sample handshake plus tap read-out bundle between upstream,
//                ffe_sample_sequencer and ffe_datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ffe_sample_sequencer_if #(
    parameter int IN_OUT_BUS_WIDTH = 12,
    parameter int ADDR_SIZE        = 2
);
    logic                               x_valid;
    logic signed [IN_OUT_BUS_WIDTH-1:0] x_in;
    logic                               x_ready;
    logic        [ADDR_SIZE-1:0]        rd_addr;
    logic signed [IN_OUT_BUS_WIDTH-1:0] rd_data;
    logic                               str_out_n_rst_add_reg;
    logic                               busy;

    // Environment side: offers samples, consumes the tap stream
    modport master (
        output x_valid, x_in,
        input  x_ready, rd_addr, rd_data, str_out_n_rst_add_reg, busy
    );

    // Sequencer side
    modport slave (
        input  x_valid, x_in,
        output x_ready, rd_addr, rd_data, str_out_n_rst_add_reg, busy
    );
endinterface
`default_nettype wire

// File: rtl/ffe_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ffe_sample_sequencer
//  Description : Keeps a DEPTH-entry sample history and, for every accepted
//                sample, issues one frame of (tap index, x[n-k]) pairs to the
//                FFE datapath followed by an output/clear strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module ffe_sample_sequencer #(
    parameter int IN_OUT_BUS_WIDTH = 12,
    parameter int DEPTH            = 4,     // must be >= 2
    parameter int ADDR_SIZE        = $clog2(DEPTH)
) (
    input  wire logic             ffe_clk,
    input  wire logic             rst,
    ffe_sample_sequencer_if.slave seq
);

    localparam logic [ADDR_SIZE-1:0] c_last_tap  = ADDR_SIZE'(DEPTH - 1);
    localparam logic [ADDR_SIZE-1:0] c_one       = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE:0]   c_depth_ext = (ADDR_SIZE + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic        [ADDR_SIZE-1:0]        r_k;
    logic        [ADDR_SIZE-1:0]        w_k_nxt;
    logic        [ADDR_SIZE-1:0]        r_wp;
    logic signed [IN_OUT_BUS_WIDTH-1:0] r_hist [DEPTH];
    logic                               r_strobe;

    logic                               w_last_tap;
    logic                               w_accept;
    logic        [ADDR_SIZE-1:0]        w_newest;
    logic        [ADDR_SIZE:0]          w_wrap_idx;
    logic        [ADDR_SIZE-1:0]        w_rd_idx;

    // Final tap of a frame is the only ISSUE cycle that can take a new sample,
    // which lets frames run back to back without a bubble.
    assign w_last_tap    = (r_state == ST_ISSUE) && (r_k == c_last_tap);
    // Ready is forced low while reset is held, even though the state is IDLE.
    assign seq.x_ready   = ((r_state == ST_IDLE) || w_last_tap) && !rst;
    assign w_accept      = seq.x_valid && seq.x_ready;
    assign seq.str_out_n_rst_add_reg = r_strobe;

    // Index of x[n-k]: newest entry is one behind the write pointer, then walk back k
    assign w_newest   = (r_wp == '0) ? c_last_tap : (r_wp - c_one);
    assign w_wrap_idx = {1'b0, w_newest} + c_depth_ext - {1'b0, r_k};
    assign w_rd_idx   = (w_newest >= r_k) ? (w_newest - r_k) : w_wrap_idx[ADDR_SIZE-1:0];

    // FSM state and tap counter register
    always_ff @(posedge ffe_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Next-state, tap counter and read-out outputs
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        seq.rd_addr = '0;
        seq.rd_data = '0;
        seq.busy    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                    w_k_nxt     = '0;
                end
            end
            ST_ISSUE: begin
                seq.rd_addr = r_k;
                seq.rd_data = r_hist[w_rd_idx];
                seq.busy    = 1'b1;
                if (r_k == c_last_tap) begin
                    w_state_nxt = w_accept ? ST_ISSUE : ST_IDLE;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt     = r_k + c_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_k_nxt     = '0;
            end
        endcase
    end

    // Circular sample history; unwritten entries stay zero for zero-padded history
    always_ff @(posedge ffe_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
            r_wp <= '0;
        end else if (w_accept) begin
            r_hist[r_wp] <= seq.x_in;
            r_wp         <= (r_wp == c_last_tap) ? '0 : (r_wp + c_one);
        end
    end

    // Output/clear strobe lands the cycle after the last tap is presented
    always_ff @(posedge ffe_clk or posedge rst) begin
        if (rst) begin
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_last_tap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ffe_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ffe_sample_sequencer
//  Description : Randomized self-checking bench. A schedule of expected
//                (addr, data, strobe) per cycle is built from the accepted
//                sample history; a small ffe_datapath model checks y values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ffe_sample_sequencer;

    localparam int W    = 12;
    localparam int D    = 4;
    localparam int A    = $clog2(D);
    localparam int MAXC = 4096;

    logic ffe_clk = 1'b0;
    logic rst     = 1'b1;

    ffe_sample_sequencer_if #(.IN_OUT_BUS_WIDTH(W), .ADDR_SIZE(A)) bus ();

    ffe_sample_sequencer #(
        .IN_OUT_BUS_WIDTH (W),
        .DEPTH            (D),
        .ADDR_SIZE        (A)
    ) dut (
        .ffe_clk (ffe_clk),
        .rst     (rst),
        .seq     (bus.slave)
    );

    always #5 ffe_clk = ~ffe_clk;

    // Expected behaviour per cycle
    bit  sch_tap  [MAXC];
    int  sch_addr [MAXC];
    int  sch_data [MAXC];
    bit  sch_stb  [MAXC];

    int     hist [$];       // accepted samples, oldest first
    int     pend [$];       // samples waiting to be offered upstream
    longint y_q  [$];       // expected datapath outputs, in strobe order
    longint y_seen [$];     // datapath outputs observed since last reset
    int     h [D] = '{1024, -512, 320, -128};

    int     errors;
    int     checks;
    int     cyc;
    bit     offering;
    longint acc;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, update model
    task automatic step(input bit rst_now, input bit offer);
        bit     exp_ready;
        longint y_exp;
        longint y_obs;
        longint prod;
        rst = rst_now;
        if (pend.size() > 0 && offer) offering = 1'b1;
        bus.x_valid = offering;
        bus.x_in    = offering ? W'(pend[0]) : W'($urandom);
        @(negedge ffe_clk);

        if (rst_now) begin
            for (int c = cyc; c < MAXC; c++) begin
                sch_tap[c] = 1'b0; sch_addr[c] = 0; sch_data[c] = 0; sch_stb[c] = 1'b0;
            end
            hist.delete();
            y_q.delete();
            y_seen.delete();
            acc = 0;
        end

        // Ready whenever no tap is already committed to the following cycle
        exp_ready = !rst_now && !sch_tap[cyc + 1];
        check_val("x_ready", longint'(bus.x_ready), longint'(exp_ready));
        check_val("rd_addr", longint'(bus.rd_addr), longint'(sch_addr[cyc]));
        check_val("rd_data", longint'($signed(bus.rd_data)), longint'(sch_data[cyc]));
        check_val("strobe",  longint'(bus.str_out_n_rst_add_reg), longint'(sch_stb[cyc]));
        check_val("busy",    longint'(bus.busy), longint'(sch_tap[cyc]));

        // Downstream datapath: strobe outputs the sum and restarts with this cycle's product
        if (!rst_now) begin
            prod = longint'(h[bus.rd_addr]) * longint'($signed(bus.rd_data));
            if (bus.str_out_n_rst_add_reg) begin
                y_obs = acc >>> 11;
                y_seen.push_back(y_obs);
                if (y_q.size() > 0) check_val("y_out", y_obs, y_q.pop_front());
                acc = prod;
            end else begin
                acc = acc + prod;
            end
        end

        if (offering && exp_ready) begin
            hist.push_back(pend.pop_front());
            if (hist.size() > D) void'(hist.pop_front());
            offering = 1'b0;
            y_exp = 0;
            for (int k = 0; k < D; k++) begin
                sch_tap[cyc + 1 + k]  = 1'b1;
                sch_addr[cyc + 1 + k] = k;
                sch_data[cyc + 1 + k] = (k < hist.size()) ? hist[hist.size() - 1 - k] : 0;
                y_exp += longint'(h[k]) * longint'(sch_data[cyc + 1 + k]);
            end
            sch_stb[cyc + D + 1] = 1'b1;
            y_q.push_back(y_exp >>> 11);
        end

        @(posedge ffe_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic send_all();
        for (int i = 0; i < 60 && pend.size() > 0; i++) step(1'b0, 1'b1);
        check_val("send_done", longint'(pend.size()), 0);
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; offering = 1'b0; acc = 0;
        bus.x_valid = 1'b0;
        bus.x_in    = '0;

        // Single sample
        do_reset();
        pend.push_back(100);
        step(1'b0, 1'b1);
        repeat (7) step(1'b0, 1'b0);

        // History order with wrap, random gaps between samples
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            pend.push_back(100 * v);
            repeat ($urandom_range(0, 6)) step(1'b0, 1'b0);
            send_all();
        end
        repeat (6) step(1'b0, 1'b0);

        // Back to back with valid held high
        do_reset();
        for (int i = 0; i < 8; i++) pend.push_back(int'($urandom_range(0, 4095)) - 2048);
        repeat (40) step(1'b0, 1'b1);

        // Stall: second sample offered at tap 1 of an active frame
        do_reset();
        pend.push_back(11);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        pend.push_back(22);
        send_all();
        repeat (6) step(1'b0, 1'b0);

        // Reset asserted while tap 2 is being presented
        do_reset();
        pend.push_back(33);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        pend.push_back(7);
        step(1'b0, 1'b1);
        repeat (7) step(1'b0, 1'b0);

        // Datapath integration
        do_reset();
        pend.push_back(1000);
        pend.push_back(2000);
        send_all();
        repeat (8) step(1'b0, 1'b0);
        check_val("s6_count", longint'(y_seen.size()), 2);
        if (y_seen.size() >= 2) begin
            check_val("s6_y0", y_seen[0], 500);
            check_val("s6_y1", y_seen[1], 750);
        end

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if (pend.size() < 3 && $urandom_range(0, 3) == 0)
                pend.push_back(int'($urandom_range(0, 4095)) - 2048);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0);
        end
        repeat (8) step(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ffe_sample_sequencer.md
FFE_SAMPLE_SEQUENCER -- requirements
Module: ffe_sample_sequencer

Interface
REQ-001 SHALL have parameter IN_OUT_BUS_WIDTH, default 12: width of the input sample and rd_data, signed two's complement.
REQ-002 SHALL have parameter DEPTH, default 4: number of taps, which is also the sample-history length.
REQ-003 SHALL have parameter ADDR_SIZE, default $clog2(DEPTH): width of rd_addr.
REQ-004 Port ffe_clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1: reset, asynchronous and active-high.
REQ-006 Port x_valid  in  1: upstream sample x_in is valid.
REQ-007 Port x_in  in  IN_OUT_BUS_WIDTH: new signed sample x[n].
REQ-008 Port x_ready  out  1: the block accepts x_in on this edge if x_valid is also high.
REQ-009 Port rd_addr  out  ADDR_SIZE: tap/coefficient index k presented to ffe_datapath.
REQ-010 Port rd_data  out  IN_OUT_BUS_WIDTH: signed sample x[n-k] paired with rd_addr.
REQ-011 Port str_out_n_rst_add_reg  out  1: one-cycle strobe telling ffe_datapath to output the sum and clear its accumulator.
REQ-012 Port busy  out  1: a frame is being issued (state ISSUE).

Function
REQ-013 SHALL keep a DEPTH-entry circular history buffer plus a write pointer wp (ADDR_SIZE bits) that wraps DEPTH-1 -> 0.
REQ-014 A sample SHALL be accepted only on an edge where x_valid && x_ready.
- On acceptance, x_in is written to buf[wp], wp increments mod DEPTH, and a frame starts.
REQ-015 State machine SHALL have states IDLE and ISSUE, with a tap counter k of 0..DEPTH-1.
- IDLE -> ISSUE on acceptance, with k = 0.
- In ISSUE, k increments each cycle.
- At k = DEPTH-1: go to ISSUE with k = 0 if a new sample is accepted that edge; otherwise go to IDLE.
REQ-016 In ISSUE, outputs SHALL be rd_addr = k and rd_data = buf[(newest - k) mod DEPTH].
- newest is the index of the most recently accepted sample.
REQ-017 In IDLE, outputs SHALL be rd_data = 0 and rd_addr = 0, so the downstream multiplier registers a zero product.
REQ-018 str_out_n_rst_add_reg SHALL be registered high for exactly the one cycle after the cycle in which tap DEPTH-1 was presented; otherwise it is low.
REQ-019 x_ready SHALL be high in IDLE, and high in ISSUE only when k = DEPTH-1; otherwise it is low.
- Result: back-to-back frames every DEPTH cycles with no bubble.
REQ-020 Back-to-back frames: the strobe for frame n SHALL coincide with tap 0 of frame n+1.
REQ-021 Latency: acceptance at edge E0 SHALL give tap 0 in cycle E0+1, tap DEPTH-1 in cycle E0+DEPTH, and the strobe in cycle E0+DEPTH+1.
REQ-022 If x_valid is high while x_ready is low, the sample SHALL NOT be consumed and no state changes; upstream holds the sample.
REQ-023 Buffer entries never written since reset SHALL read as 0, giving zero-padded history for the first DEPTH-1 frames.
REQ-024 Sample data SHALL pass through unmodified: no arithmetic, truncation or sign change on the path to rd_data.

Reset
REQ-025 While rst is high, the block SHALL asynchronously clear:
- all buffer entries and wp to 0;
- state to IDLE and k to 0;
- rd_addr = 0, rd_data = 0, str_out_n_rst_add_reg = 0, busy = 0, x_ready = 0.
REQ-026 The first cycle after rst deasserts SHALL have x_ready = 1.
REQ-027 Reset mid-frame SHALL discard the partial frame: no strobe is issued for it, and the history is lost.

Verification
REQ-028 Scenario 1, single sample: reset, then accept x=100.
- rd_addr/rd_data over the next 4 cycles = 0/100, 1/0, 2/0, 3/0.
- Strobe in the 5th cycle; busy high for 4 cycles.
REQ-029 Scenario 2, history order: accept 100, then 200, then 300, then 400, then 500.
- The 5th frame issues rd_data = 500, 400, 300, 200 (wrap of wp exercised).
REQ-030 Scenario 3, back-to-back: hold x_valid=1 continuously.
- x_ready pulses every 4th cycle.
- Each strobe coincides with rd_addr=0 of the next frame.
- No idle cycles between frames.
REQ-031 Scenario 4, stall: assert x_valid at k=1 of an active frame.
- x_ready stays 0; the sample is accepted only at k=3; the value is unchanged.
REQ-032 Scenario 5, reset mid-frame: assert rst at k=2.
- All outputs go to 0 immediately and no strobe occurs.
- Next accepted x=7 issues 7, 0, 0, 0.
REQ-033 Scenario 6, integration with ffe_datapath (h = 1024, -512, 320, -128):
- After reset, accept x=1000: y = 500 in the strobe cycle.
- Then accept x=2000: next strobe y = 750.
